// File: rtl/psram_bist_pkg.sv
// psram_bist_pkg: shared state, pattern and fail encodings for the PSRAM BIST.
// Holds the LFSR constants and the data pattern function used for write and compare.
package psram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    PAT_HASH = 2'd0,
    PAT_ADDR = 2'd1,
    PAT_WALK = 2'd2,
    PAT_LFSR = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_INIT = 2'd1,
    FC_WR   = 2'd2,
    FC_RD   = 2'd3
  } fail_e;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Byte accesses replicate the low byte onto both lanes.
  function automatic logic [15:0] pat_fn(
    input logic [15:0] a,
    input logic [15:0] lfsr,
    input pat_e        code,
    input logic        word
  );
    logic [15:0] v;
    unique case (code)
      PAT_HASH: v = {8'h00, 8'(a[7:0] + 8'h01)};
      PAT_ADDR: v = a;
      PAT_WALK: v = 16'h0001 << a[4:1];
      PAT_LFSR: v = lfsr;
    endcase
    return word ? v : {v[7:0], v[7:0]};
  endfunction

endpackage

// File: rtl/psram_bist_pattern.sv
// psram_bist_pattern: data pattern generator with its LFSR register.
// The same sequence is replayed for writing and for the expected read data.
module psram_bist_pattern
  import psram_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reseed,
  input  logic        advance,
  input  logic [1:0]  code,
  input  logic        word,
  input  logic [15:0] addr,
  output logic [15:0] data
);

  logic [15:0] lfsr;

  // LFSR state; reseed wins over advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (reseed) lfsr <= LFSR_SEED;
    else if (advance) lfsr <= lfsr_step(lfsr);
  end

  // Pattern value for the current address and LFSR state
  always_comb begin
    data = pat_fn(addr, lfsr, pat_e'(code), word);
  end

endmodule

// File: rtl/psram_bist.sv
// psram_bist: windowed write-then-read self test on the PsramController request port.
// Build macro PSRAM_BIST_LAT_STATS_EN adds wr_1x/wr_2x/rd_1x/rd_2x latency tallies.
module psram_bist
  import psram_bist_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 24,
  parameter int INIT_TIMEOUT = 40_500_000,
  parameter int WR_TIMEOUT   = 11,
  parameter int RD_TIMEOUT   = 16,
  parameter int WR_2X_THRESH = 7,
  parameter int RD_2X_THRESH = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern,
  input  logic              word_mode,
  input  logic              stop_on_err,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       fail_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy
`ifdef PSRAM_BIST_LAT_STATS_EN
  ,
  output logic [CNT_W-1:0]  wr_1x,
  output logic [CNT_W-1:0]  wr_2x,
  output logic [CNT_W-1:0]  rd_1x,
  output logic [CNT_W-1:0]  rd_2x
`endif
);

  if (DATA_W != 16) begin : g_dw_chk
    $error("psram_bist: DATA_W must be 16");
  end
  if (ADDR_W < 16) begin : g_aw_chk
    $error("psram_bist: ADDR_W must be at least 16");
  end
  if (WR_2X_THRESH >= WR_TIMEOUT || RD_2X_THRESH >= RD_TIMEOUT) begin : g_th_chk
    $error("psram_bist: 2x thresholds must lie below the timeouts");
  end

  state_e            state;
  logic [31:0]       tmr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_q;
  logic [8:0]        inc_lo;
  logic [1:0]        pat_q;
  logic              word_q;
  logic              stop_q;
  logic [15:0]       exp_q;

  logic [ADDR_W-1:0] base_m;
  logic [ADDR_W-1:0] last_m;
  logic [ADDR_W-1:0] addr_inc;
  logic              is_last;
  logic [7:0]        lane;
  logic              miss;
  logic              pat_reseed;
  logic              pat_adv;
  logic [15:0]       pat_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Window setup, address step, compare and pattern control decode
  always_comb begin
    base_m = base_addr;
    last_m = last_addr;
    if (word_mode) begin
      base_m[0] = 1'b0;
      last_m[0] = 1'b0;
    end
    addr_inc = {addr_q[ADDR_W-1:8] + (ADDR_W-8)'(inc_lo[8]), inc_lo[7:0]};
    is_last = (addr_q == last_q);
    lane = addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];
    miss = word_q ? (mem_dout != exp_q) : (lane != exp_q[7:0]);
    pat_reseed = (state == S_INIT) || (state == S_WR_WAIT && is_last);
    pat_adv = (state == S_WR_ISSUE) || (state == S_RD_ISSUE);
  end

  psram_bist_pattern u_pat (
    .clk     (clk),
    .reset   (reset),
    .reseed  (pat_reseed),
    .advance (pat_adv),
    .code    (pat_q),
    .word    (word_q),
    .addr    (addr_q[15:0]),
    .data    (pat_data)
  );

  // Test sequencer with registered request and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      tmr            <= '0;
      addr_q         <= '0;
      base_q         <= '0;
      last_q         <= '0;
      inc_lo         <= '0;
      pat_q          <= '0;
      word_q         <= 1'b0;
      stop_q         <= 1'b0;
      exp_q          <= '0;
      running        <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_code      <= FC_NONE;
      err_count      <= '0;
      fail_addr      <= '0;
      fail_data      <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
`ifdef PSRAM_BIST_LAT_STATS_EN
      wr_1x          <= '0;
      wr_2x          <= '0;
      rd_1x          <= '0;
      rd_2x          <= '0;
`endif
    end else begin
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q         <= base_m;
            last_q         <= (last_m < base_m) ? base_m : last_m;
            addr_q         <= base_m;
            pat_q          <= pattern;
            word_q         <= word_mode;
            stop_q         <= stop_on_err;
            mem_byte_write <= ~word_mode;
            running        <= 1'b1;
            pass           <= 1'b0;
            fail_code      <= FC_NONE;
            err_count      <= '0;
            fail_addr      <= '0;
            fail_data      <= '0;
            tmr            <= '0;
`ifdef PSRAM_BIST_LAT_STATS_EN
            wr_1x          <= '0;
            wr_2x          <= '0;
            rd_1x          <= '0;
            rd_2x          <= '0;
`endif
            state          <= S_INIT;
          end
        end
        S_INIT: begin
          if (!mem_busy) begin
            state <= S_WR_ISSUE;
          end else if (tmr >= 32'(INIT_TIMEOUT - 1)) begin
            fail_code <= FC_INIT;
            fail_addr <= base_q;
            state     <= S_FIN;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_WR_ISSUE: begin
          mem_write <= 1'b1;
          mem_addr  <= {addr_q[ADDR_W-1:1], addr_q[0] & ~word_q};
          mem_din   <= pat_data;
          inc_lo    <= {1'b0, addr_q[7:0]} + {7'd0, word_q, ~word_q};
          tmr       <= '0;
          state     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          tmr <= tmr + 32'd1;
          if (tmr >= 32'd2 && !mem_busy) begin
`ifdef PSRAM_BIST_LAT_STATS_EN
            if (tmr > 32'(WR_2X_THRESH)) wr_2x <= sat_inc(wr_2x);
            else wr_1x <= sat_inc(wr_1x);
`endif
            if (is_last) begin
              addr_q <= base_q;
              state  <= S_RD_ISSUE;
            end else begin
              addr_q <= addr_inc;
              state  <= S_WR_ISSUE;
            end
          end else if (tmr == 32'(WR_TIMEOUT)) begin
            fail_code <= FC_WR;
            fail_addr <= addr_q;
            state     <= S_FIN;
          end
        end
        S_RD_ISSUE: begin
          mem_read <= 1'b1;
          mem_addr <= {addr_q[ADDR_W-1:1], addr_q[0] & ~word_q};
          exp_q    <= pat_data;
          inc_lo   <= {1'b0, addr_q[7:0]} + {7'd0, word_q, ~word_q};
          tmr      <= '0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          tmr <= tmr + 32'd1;
          if (tmr >= 32'd2 && !mem_busy) begin
`ifdef PSRAM_BIST_LAT_STATS_EN
            if (tmr > 32'(RD_2X_THRESH)) rd_2x <= sat_inc(rd_2x);
            else rd_1x <= sat_inc(rd_1x);
`endif
            if (miss) begin
              err_count <= sat_inc(err_count);
              if (err_count == '0) begin
                fail_addr <= addr_q;
                fail_data <= mem_dout;
              end
            end
            if ((miss && stop_q) || is_last) begin
              state <= S_FIN;
            end else begin
              addr_q <= addr_inc;
              state  <= S_RD_ISSUE;
            end
          end else if (tmr == 32'(RD_TIMEOUT)) begin
            fail_code <= FC_RD;
            fail_addr <= addr_q;
            state     <= S_FIN;
          end
        end
        S_FIN: begin
          done    <= 1'b1;
          pass    <= (err_count == '0) && (fail_code == FC_NONE);
          running <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bist.sv
// tb_psram_bist: directed checks of psram_bist against a behavioural PSRAM model.
// The model adds optional random 1x/2x latency, a corrupted byte and stuck-busy faults.
module tb_psram_bist;

  localparam int AW = 22;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    pattern;
  logic          word_mode;
  logic          stop_on_err;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] last_addr;
  logic          running;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [CW-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [15:0]   fail_data;
  logic          mem_read;
  logic          mem_write;
  logic          mem_byte_write;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;
  logic          mem_busy;
`ifdef PSRAM_BIST_LAT_STATS_EN
  logic [CW-1:0] wr_1x, wr_2x, rd_1x, rd_2x;
`endif

  always #5 clk = ~clk;

  psram_bist #(.ADDR_W(AW), .CNT_W(CW), .INIT_TIMEOUT(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pattern        (pattern),
    .word_mode      (word_mode),
    .stop_on_err    (stop_on_err),
    .base_addr      (base_addr),
    .last_addr      (last_addr),
    .running        (running),
    .done           (done),
    .pass           (pass),
    .fail_code      (fail_code),
    .err_count      (err_count),
    .fail_addr      (fail_addr),
    .fail_data      (fail_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_write (mem_byte_write),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_busy       (mem_busy)
`ifdef PSRAM_BIST_LAT_STATS_EN
    ,
    .wr_1x          (wr_1x),
    .wr_2x          (wr_2x),
    .rd_1x          (rd_1x),
    .rd_2x          (rd_2x)
`endif
  );

  // model controls
  logic          hold_rst = 1'b0;
  logic          hold_en = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic          cor_en = 1'b0;
  logic [AW-1:0] cor_addr = '0;
  logic          rand_lat = 1'b0;

  logic [7:0]    mem [0:4095];
  logic          stuck;
  int            left;
  bit            k2;
  logic [11:0]   ra;
  logic [15:0]   mask;

  int wr_n = 0, rd_n = 0, wr2_n = 0, rd2_n = 0;
  int both_n = 0, odd_n = 0, rd43_n = 0;
  logic [AW-1:0] last_wa = '0;
  int cyc = 0, t_hold = 0;

  // Behavioural PSRAM: one request at a time, busy for a fixed 1x or 2x span
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy <= hold_rst;
      stuck    <= hold_rst;
      left     <= 0;
      mem_dout <= '0;
    end else begin
      if (mem_read && mem_write) both_n <= both_n + 1;
      if ((mem_read || mem_write) && !mem_byte_write && mem_addr[0]) odd_n <= odd_n + 1;
      if (mem_read && mem_addr == AW'(12'h043)) rd43_n <= rd43_n + 1;
      if (mem_write) begin
        wr_n    <= wr_n + 1;
        last_wa <= mem_addr;
        if (mem_byte_write) begin
          mem[mem_addr[11:0]] <= mem_addr[0] ? mem_din[15:8] : mem_din[7:0];
        end else begin
          mem[{mem_addr[11:1], 1'b0}] <= mem_din[7:0];
          mem[{mem_addr[11:1], 1'b1}] <= mem_din[15:8];
        end
        k2 = rand_lat && ($urandom_range(0, 1) == 1);
        if (k2) wr2_n <= wr2_n + 1;
        mem_busy <= 1'b1;
        left     <= k2 ? 9 : 3;
        stuck    <= hold_en && (mem_addr == hold_addr);
      end else if (mem_read) begin
        rd_n <= rd_n + 1;
        ra = {mem_addr[11:1], 1'b0};
        mask = (cor_en && mem_addr[11:1] == cor_addr[11:1]) ?
               (cor_addr[0] ? 16'h0800 : 16'h0008) : 16'h0000;
        mem_dout <= {mem[ra | 12'h001], mem[ra]} ^ mask;
        k2 = rand_lat && ($urandom_range(0, 1) == 1);
        if (k2) rd2_n <= rd2_n + 1;
        mem_busy <= 1'b1;
        left     <= k2 ? 13 : 5;
      end else if (mem_busy && !stuck) begin
        if (left <= 1) mem_busy <= 1'b0;
        left <= left - 1;
      end
    end
  end

  // cycle stamp of the write that gets stuck
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write && mem_addr == hold_addr) t_hold <= cyc;
  end

  int n_tests = 0;
  int n_fail = 0;
  int w0, r0, w20, r20, o0, c0, lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_test(input logic [AW-1:0] b, input logic [AW-1:0] l,
                            input logic [1:0] p, input logic w, input logic s);
    @(negedge clk);
    base_addr   = b;
    last_addr   = l;
    pattern     = p;
    word_mode   = w;
    stop_on_err = s;
    start       = 1'b1;
    w0  = wr_n;
    r0  = rd_n;
    w20 = wr2_n;
    r20 = rd2_n;
    o0  = odd_n;
    c0  = rd43_n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (poke && i == 100) begin
        start     = 1'b1;
        pattern   = 2'd3;
        word_mode = 1'b1;
        base_addr = AW'(12'h055);
      end
      if (poke && i == 101) start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pattern = '0;
    word_mode = 1'b0;
    stop_on_err = 1'b0;
    base_addr = '0;
    last_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", {running, done, pass, fail_code, mem_read, mem_write, mem_byte_write}, 0);
    check("rst_err", err_count, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    reset = 1'b0;

    // byte hash 0x000..0x0FF, random latency, start/config poked mid-run
    rand_lat = 1'b1;
    start_test('0, AW'(12'h0FF), 2'd0, 1'b0, 1'b0);
    check("t1_running", running, 1);
    wait_done(20000, 1'b1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_fc", fail_code, 0);
    check("t1_writes", wr_n - w0, 256);
    check("t1_reads", rd_n - r0, 256);
    check("t1_mem00", mem[0], 8'h01);
    check("t1_mem80", mem[12'h080], 8'h81);
    check("t1_memff", mem[12'h0FF], 8'h00);
    check("t1_excl", both_n, 0);
`ifdef PSRAM_BIST_LAT_STATS_EN
    check("t1_wr_sum", wr_1x + wr_2x, 256);
    check("t1_rd_sum", rd_1x + rd_2x, 256);
    check("t1_wr2", wr_2x, wr2_n - w20);
    check("t1_rd2", rd_2x, rd2_n - r20);
`endif
    @(negedge clk);
    check("t1_done_pulse", {done, running}, 0);

    // word LFSR 0x100..0x11F
    start_test(AW'(12'h100), AW'(12'h11F), 2'd3, 1'b1, 1'b0);
    wait_done(5000, 1'b0);
    check("t2_pass", pass, 1);
    check("t2_writes", wr_n - w0, 16);
    check("t2_reads", rd_n - r0, 16);
    check("t2_odd", odd_n - o0, 0);
    check("t2_last_wa", last_wa, AW'(12'h11E));
    check("t2_w0", {mem[12'h101], mem[12'h100]}, 16'hACE1);
    check("t2_w1", {mem[12'h103], mem[12'h102]}, 16'h5670);
    check("t2_w2", {mem[12'h105], mem[12'h104]}, 16'hAB38);

    // corrupted bit 3 of byte 0x042, run to end
    rand_lat = 1'b0;
    cor_en = 1'b1;
    cor_addr = AW'(12'h042);
    start_test('0, AW'(12'h0FF), 2'd0, 1'b0, 1'b0);
    wait_done(20000, 1'b0);
    check("t3_err", err_count, 1);
    check("t3_faddr", fail_addr, AW'(12'h042));
    check("t3_fdata", fail_data, 16'h444B);
    check("t3_pass", pass, 0);
    check("t3_fc", fail_code, 0);
    check("t3_reads", rd_n - r0, 256);

    // same corruption, stop at first error
    start_test('0, AW'(12'h0FF), 2'd0, 1'b0, 1'b1);
    wait_done(20000, 1'b0);
    check("t4_err", err_count, 1);
    check("t4_reads", rd_n - r0, 67);
    check("t4_rd43", rd43_n - c0, 0);
    check("t4_faddr", fail_addr, AW'(12'h042));
    check("t4_pass", pass, 0);

    // busy stuck after the write to 0x010
    cor_en = 1'b0;
    hold_en = 1'b1;
    hold_addr = AW'(12'h010);
    start_test('0, AW'(12'h0FF), 2'd0, 1'b0, 1'b0);
    wait_done(5000, 1'b0);
    lat = cyc - t_hold;
    check("t5_fc", fail_code, 2);
    check("t5_faddr", fail_addr, AW'(12'h010));
    check("t5_pass", pass, 0);
    check("t5_writes", wr_n - w0, 17);
    check("t5_lat_window", (lat >= 11 && lat <= 13), 1);

    // busy held from reset: init timeout
    hold_en = 1'b0;
    hold_rst = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_test('0, AW'(12'h0FF), 2'd0, 1'b0, 1'b0);
    wait_done(500, 1'b0);
    check("t6_fc", fail_code, 1);
    check("t6_pass", pass, 0);
    check("t6_writes", wr_n - w0, 0);
    hold_rst = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // last < base, then base == last
    start_test(AW'(12'h020), AW'(12'h010), 2'd1, 1'b0, 1'b0);
    wait_done(500, 1'b0);
    check("t7_writes", wr_n - w0, 1);
    check("t7_reads", rd_n - r0, 1);
    check("t7_addr", last_wa, AW'(12'h020));
    check("t7_pass", pass, 1);
    start_test(AW'(12'h030), AW'(12'h030), 2'd2, 1'b0, 1'b0);
    wait_done(500, 1'b0);
    check("t8_counts", {16'(wr_n - w0), 16'(rd_n - r0)}, 32'h0001_0001);
    check("t8_pass", pass, 1);

    // reset during a read wait, then a clean rerun
    start_test('0, AW'(12'h00F), 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2000 && (rd_n - r0) < 3; i++) @(negedge clk);
    check("t9_in_read", (rd_n - r0) >= 3, 1);
    reset = 1'b1;
    #1;
    check("t9_rst_flags", {running, done, pass, fail_code, mem_read, mem_write, mem_byte_write}, 0);
    check("t9_rst_addr", mem_addr, 0);
    check("t9_rst_din", mem_din, 0);
    @(negedge clk);
    reset = 1'b0;
    start_test('0, AW'(12'h00F), 2'd0, 1'b0, 1'b0);
    wait_done(2000, 1'b0);
    check("t9_pass", pass, 1);
    check("t9_reads", rd_n - r0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
